// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared constants, encodings and predictor entry type
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int DBITS = 16;
   localparam int ABITS = 8;
   localparam int CBITS = 2;
   localparam int SBITS = 16;
   localparam int TBITS = DBITS - ABITS - 1;

   typedef enum logic [3:0] {
      OP1_ALU  = 4'h0,
      OP1_LDI  = 4'h1,
      OP1_LD   = 4'h2,
      OP1_ST   = 4'h3,
      OP1_BEQ  = 4'h4,
      OP1_BNE  = 4'h5,
      OP1_JMP  = 4'h6,
      OP1_JAL  = 4'h7
   } opcode1_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SHL = 3'd5,
      ALU_SHR = 3'd6,
      ALU_SLT = 3'd7
   } alu_fn_t;

   localparam logic [CBITS-1:0] CTR_SNT = 2'b00;
   localparam logic [CBITS-1:0] CTR_WNT = 2'b01;
   localparam logic [CBITS-1:0] CTR_WT  = 2'b10;
   localparam logic [CBITS-1:0] CTR_ST  = 2'b11;

   typedef struct packed {
      logic             valid;
      logic [TBITS-1:0] tag;
      logic [DBITS-1:0] target;
      logic [CBITS-1:0] ctr;
   } pred_entry_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : combinational saturating increment/decrement
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int CBITS = 2
) (
   input  logic [CBITS-1:0] cur,
   input  logic             inc,
   input  logic             dec,
   output logic [CBITS-1:0] nxt
);

   localparam logic [CBITS-1:0] C_MAX = {CBITS{1'b1}};
   localparam logic [CBITS-1:0] C_MIN = {CBITS{1'b0}};

   // Simultaneous inc and dec cancel out.
   always_comb begin
      nxt = cur;
      if (inc && !dec && cur != C_MAX)
         nxt = cur + CBITS'(1);
      else if (dec && !inc && cur != C_MIN)
         nxt = cur - CBITS'(1);
   end

endmodule

`default_nettype wire

// File: rtl/fetch_predictor.sv
// ============================================================================
// fetch_predictor : tagged, counter-based next-PC predictor with statistics
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fetch_predictor #(
   parameter int DBITS = 16,
   parameter int ABITS = 8,
   parameter int CBITS = 2,
   parameter int SBITS = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [DBITS-1:0] fetch_pc,
   input  logic             fetch_en,
   output logic [DBITS-1:0] pred_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   input  logic             upd_en,
   input  logic [DBITS-1:0] upd_pc,
   input  logic             upd_taken,
   input  logic [DBITS-1:0] upd_target,
   input  logic             upd_mispredict,
   input  logic             inv_all,
   output logic [SBITS-1:0] stat_lookups,
   output logic [SBITS-1:0] stat_mispredicts
);

   import cpu_pkg::*;

   localparam int ENTRIES = 2**ABITS;
   localparam int TBITS   = DBITS - ABITS - 1;

   logic [ENTRIES-1:0] valid;
   logic [TBITS-1:0]   tag_mem    [ENTRIES];
   logic [DBITS-1:0]   target_mem [ENTRIES];
   logic [CBITS-1:0]   ctr_mem    [ENTRIES];

   logic [ABITS-1:0]   fetch_idx;
   logic [TBITS-1:0]   fetch_tag;
   logic [ABITS-1:0]   upd_idx;
   logic [TBITS-1:0]   upd_tag;
   pred_entry_t        lk;
   logic               upd_hit;
   logic [CBITS-1:0]   ctr_nxt;
   logic               unused_bits;

   logic [SBITS-1:0]   lookups_q, lookups_nxt;
   logic [SBITS-1:0]   mispredicts_q, mispredicts_nxt;

   assign fetch_idx   = fetch_pc[ABITS:1];
   assign fetch_tag   = fetch_pc[DBITS-1:ABITS+1];
   assign upd_idx     = upd_pc[ABITS:1];
   assign upd_tag     = upd_pc[DBITS-1:ABITS+1];
   assign unused_bits = upd_pc[0];

   // Lookup reads the registered contents only, so a same-cycle update is invisible here.
   always_comb begin
      lk.valid  = valid[fetch_idx];
      lk.tag    = tag_mem[fetch_idx];
      lk.target = target_mem[fetch_idx];
      lk.ctr    = ctr_mem[fetch_idx];
   end

   assign pred_hit   = lk.valid && (lk.tag == fetch_tag);
   assign pred_taken = pred_hit && lk.ctr[CBITS-1];
   assign pred_pc    = pred_taken ? lk.target : fetch_pc + DBITS'(2);

   assign upd_hit = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);

   sat_counter #(.CBITS(CBITS)) u_ctr_upd (
      .cur (ctr_mem[upd_idx]),
      .inc (upd_taken),
      .dec (!upd_taken),
      .nxt (ctr_nxt)
   );

   always_ff @(posedge CLK) begin
      if (RESET || inv_all)
         valid <= '0;
      else if (upd_en && upd_taken && !upd_hit)
         valid[upd_idx] <= 1'b1;
   end

   // Payload arrays carry no reset; they are meaningless while the entry is invalid.
   always_ff @(posedge CLK) begin
      if (!RESET && !inv_all && upd_en) begin
         if (upd_hit) begin
            ctr_mem[upd_idx] <= ctr_nxt;
            if (upd_taken)
               target_mem[upd_idx] <= upd_target;
         end else if (upd_taken) begin
            tag_mem[upd_idx]    <= upd_tag;
            target_mem[upd_idx] <= upd_target;
            ctr_mem[upd_idx]    <= CTR_WT;
         end
      end
   end

   sat_counter #(.CBITS(SBITS)) u_stat_lookups (
      .cur (lookups_q),
      .inc (fetch_en),
      .dec (1'b0),
      .nxt (lookups_nxt)
   );

   sat_counter #(.CBITS(SBITS)) u_stat_mispredicts (
      .cur (mispredicts_q),
      .inc (upd_en && upd_mispredict),
      .dec (1'b0),
      .nxt (mispredicts_nxt)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         lookups_q     <= '0;
         mispredicts_q <= '0;
      end else begin
         lookups_q     <= lookups_nxt;
         mispredicts_q <= mispredicts_nxt;
      end
   end

   assign stat_lookups     = lookups_q;
   assign stat_mispredicts = mispredicts_q;

endmodule

`default_nettype wire
